// File: rtl/oled_init_sequencer.sv
// Power-up/init sequencer for an SSD1306-style OLED panel.
// Walks a fixed step table of supply switches, delays and command bytes for an SPI byte sender.
module oled_init_sequencer #(
  parameter int CYCLES_PER_MS = 100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       SPI_FIN,
  output logic       SPI_EN,
  output logic [7:0] SPI_DATA,
  output logic       DC,
  output logic       RES,
  output logic       VBAT,
  output logic       VDD,
  output logic       FIN
);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_SEND, S_WAIT_FIN_LOW, S_DELAY, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    K_SEND, K_VDD, K_RESET, K_VBAT, K_DONE
  } kind_e;

  localparam logic [31:0] CYC_LAST = 32'(CYCLES_PER_MS - 1);

  state_e      state_q;
  logic [3:0]  step_q;
  logic [31:0] cyc_q;
  logic [7:0]  ms_q;
  logic [7:0]  tgt_q;
  logic        spi_en_q;
  logic [7:0]  spi_data_q;
  logic        res_q;
  logic        vbat_q;
  logic        vdd_q;
  logic        fin_q;

  kind_e       step_kind;
  logic [7:0]  step_byte;

  // Step table; supply/reset steps carry their own delay so RES low spans just the 1 ms.
  always_comb begin
    step_kind = K_SEND;
    step_byte = 8'h00;
    case (step_q)
      4'd0:    step_kind = K_VDD;
      4'd1:    step_byte = 8'hAE;
      4'd2:    step_kind = K_RESET;
      4'd3:    step_byte = 8'h8D;
      4'd4:    step_byte = 8'h14;
      4'd5:    step_byte = 8'hD9;
      4'd6:    step_byte = 8'hF1;
      4'd7:    step_kind = K_VBAT;
      4'd8:    step_byte = 8'h81;
      4'd9:    step_byte = 8'h0F;
      4'd10:   step_byte = 8'hA1;
      4'd11:   step_byte = 8'hC8;
      4'd12:   step_byte = 8'hDA;
      4'd13:   step_byte = 8'h00;
      4'd14:   step_byte = 8'hAF;
      default: step_kind = K_DONE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      step_q     <= 4'd0;
      cyc_q      <= 32'd0;
      ms_q       <= 8'd0;
      tgt_q      <= 8'd0;
      spi_en_q   <= 1'b0;
      spi_data_q <= 8'h00;
      res_q      <= 1'b1;
      vbat_q     <= 1'b1;
      vdd_q      <= 1'b1;
      fin_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          fin_q <= 1'b0;
          if (EN) begin
            step_q  <= 4'd0;
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          cyc_q <= 32'd0;
          ms_q  <= 8'd0;
          case (step_kind)
            K_SEND: begin
              // Data and request rise together, so data never moves while SPI_EN is high.
              spi_data_q <= step_byte;
              spi_en_q   <= 1'b1;
              state_q    <= S_SEND;
            end
            K_VDD: begin
              vdd_q   <= 1'b0;
              tgt_q   <= 8'd1;
              state_q <= S_DELAY;
            end
            K_RESET: begin
              res_q   <= 1'b0;
              tgt_q   <= 8'd1;
              state_q <= S_DELAY;
            end
            K_VBAT: begin
              vbat_q  <= 1'b0;
              tgt_q   <= 8'd100;
              state_q <= S_DELAY;
            end
            default: begin
              fin_q   <= 1'b1;
              state_q <= S_DONE;
            end
          endcase
        end
        S_SEND: begin
          if (SPI_FIN) begin
            spi_en_q <= 1'b0;
            state_q  <= S_WAIT_FIN_LOW;
          end
        end
        S_WAIT_FIN_LOW: begin
          if (!SPI_FIN) begin
            step_q  <= step_q + 4'd1;
            state_q <= S_STEP;
          end
        end
        S_DELAY: begin
          if (cyc_q == CYC_LAST) begin
            cyc_q <= 32'd0;
            if (ms_q + 8'd1 == tgt_q) begin
              ms_q    <= 8'd0;
              step_q  <= step_q + 4'd1;
              state_q <= S_STEP;
              if (step_kind == K_RESET) res_q <= 1'b1;
            end else begin
              ms_q <= ms_q + 8'd1;
            end
          end else begin
            cyc_q <= cyc_q + 32'd1;
          end
        end
        S_DONE: begin
          if (!EN) begin
            fin_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign SPI_EN   = spi_en_q;
  assign SPI_DATA = spi_data_q;
  assign DC       = 1'b0;
  assign RES      = res_q;
  assign VBAT     = vbat_q;
  assign VDD      = vdd_q;
  assign FIN      = fin_q;

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Bench for oled_init_sequencer: reset/idle vector table, SPI byte-sender model and byte scoreboard.
module tb_oled_init_sequencer;
  localparam int CPM = 4;
  localparam logic [7:0] SEQ [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                      8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h00, 8'hAF};

  logic CLK = 1'b0, RST = 1'b0, EN = 1'b0, SPI_FIN = 1'b0;
  logic SPI_EN, DC, RES, VBAT, VDD, FIN;
  logic [7:0] SPI_DATA;

  int tests = 0, fails = 0;
  logic [7:0] exp_q [$];

  logic       prev_en = 1'b0;
  logic       stable = 1'b1;
  logic       saw_d9 = 1'b0;
  logic [7:0] data_at_rise = 8'h00;
  int en_cnt = 0, hold_left = 0, hold_extra = 0, res_low = 0, vbat_low = 0;

  typedef struct {
    logic        rst;
    logic        en;
    int          cycles;
    logic [13:0] exp; // {SPI_EN, SPI_DATA, DC, RES, VBAT, VDD, FIN}
  } vec_t;
  vec_t vecs [3];

  oled_init_sequencer #(.CYCLES_PER_MS(CPM)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .SPI_FIN(SPI_FIN), .SPI_EN(SPI_EN),
    .SPI_DATA(SPI_DATA), .DC(DC), .RES(RES), .VBAT(VBAT), .VDD(VDD), .FIN(FIN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_seq();
    for (int i = 0; i < 12; i++) exp_q.push_back(SEQ[i]);
  endtask

  // SPI sender model plus timing observers, run once per cycle just after the edge.
  task automatic model();
    if (VBAT == 1'b0) vbat_low++; else vbat_low = 0;
    if (RES == 1'b0) res_low++;
    else if (res_low != 0) begin
      check("res_low_len_3to5", 32'(res_low >= 3 && res_low <= 5), 32'd1);
      res_low = 0;
    end
    if (SPI_EN && !prev_en) begin
      check("no_rise_while_fin", 32'(SPI_FIN), 32'd0);
      check("dc_command", 32'(DC), 32'd0);
      check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("byte", 32'(SPI_DATA), 32'(exp_q.pop_front()));
      if (SPI_DATA == 8'h81) check("vbat_lead_ge_400", 32'(vbat_low >= 400), 32'd1);
      if (SPI_DATA == 8'hD9) saw_d9 = 1'b1;
      data_at_rise = SPI_DATA;
      stable = 1'b1;
      en_cnt = 0;
    end
    if (SPI_EN) begin
      if (SPI_DATA !== data_at_rise) stable = 1'b0;
      en_cnt++;
      if (en_cnt == 10) SPI_FIN = 1'b1;
    end
    if (!SPI_EN && prev_en) begin
      check("data_stable", 32'(stable), 32'd1);
      hold_left = hold_extra;
      if (hold_left == 0) SPI_FIN = 1'b0;
    end else if (!SPI_EN && SPI_FIN && hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) SPI_FIN = 1'b0;
    end
    prev_en = SPI_EN;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    model();
  endtask

  task automatic run_to_fin(input int budget);
    int n = 0;
    while (FIN !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("fin_reached", 32'(FIN), 32'd1);
  endtask

  initial begin
    vecs[0] = '{rst: 1'b0, en: 1'b0, cycles: 2, exp: {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}};
    vecs[1] = '{rst: 1'b1, en: 1'b0, cycles: 3, exp: {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}};
    vecs[2] = '{rst: 1'b0, en: 1'b1, cycles: 3, exp: {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}};

    for (int v = 0; v < 3; v++) begin
      RST = vecs[v].rst;
      EN  = vecs[v].en;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        tick();
        check($sformatf("vec%0d", v), 32'({SPI_EN, SPI_DATA, DC, RES, VBAT, VDD, FIN}),
              32'(vecs[v].exp));
      end
    end

    // Release reset with EN already high: supply on within two cycles, then full run.
    push_seq();
    RST = 1'b1;
    tick();
    tick();
    check("vdd_on_after_rst", 32'(VDD), 32'd0);
    run_to_fin(2000);
    check("run1_all_bytes", 32'(exp_q.size()), 32'd0);
    check("run1_res_high", 32'(RES), 32'd1);
    tick();
    check("done_holds_fin", 32'(FIN), 32'd1);

    // Drop EN back to Idle, then restart with a sender that holds FIN 5 extra cycles.
    EN = 1'b0;
    tick();
    check("fin_clear_idle", 32'(FIN), 32'd0);
    check("vdd_stays_on", 32'(VDD), 32'd0);
    hold_extra = 5;
    push_seq();
    EN = 1'b1;
    run_to_fin(3000);
    check("run2_all_bytes", 32'(exp_q.size()), 32'd0);
    hold_extra = 0;

    // Reset in the middle of the 0xD9 transfer.
    EN = 1'b0;
    tick();
    check("fin_clear_idle2", 32'(FIN), 32'd0);
    push_seq();
    saw_d9 = 1'b0;
    EN = 1'b1;
    for (int n = 0; n < 2000 && !saw_d9; n++) tick();
    check("d9_reached", 32'(saw_d9), 32'd1);
    tick();
    RST = 1'b0;
    tick();
    check("rst_mid_send", 32'({SPI_EN, VDD, VBAT, FIN}), 32'b0110);
    exp_q.delete();
    RST = 1'b1;
    EN = 1'b0;
    for (int n = 0; n < 20; n++) tick();
    check("no_bytes_after_rst", 32'(SPI_EN), 32'd0);

    // Restart; EN dropped mid-sequence must not stop it.
    push_seq();
    EN = 1'b1;
    for (int n = 0; n < 3; n++) tick();
    EN = 1'b0;
    run_to_fin(2000);
    check("run3_all_bytes", 32'(exp_q.size()), 32'd0);
    tick();
    check("fin_clear_after_done", 32'(FIN), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
